// File: rtl/seq_det_pkg.sv
// -----------------------------------------------------------------------------
// seq_det_pkg
// Shared definitions for the serial sequence detector family.
//   SEQ_LEN_MAX    : widest pattern any detector in this family accepts
//   state_width()  : bits needed to hold a match depth 0..LEN-1
//   low_mask()     : k low-order ones, used for variable-length bit compares
//   pattern_prefix(): the first k received bits of a pattern, right-aligned
//   border_len()   : overlap restart depth after a full match
// -----------------------------------------------------------------------------
package seq_det_pkg;

    localparam int SEQ_LEN_MAX = 16;

    function automatic int state_width(input int len);
        return $clog2(len);
    endfunction

    function automatic logic [SEQ_LEN_MAX-1:0] low_mask(input int k);
        logic [SEQ_LEN_MAX-1:0] m;
        m = {SEQ_LEN_MAX{1'b0}};
        for (int i = 0; i < SEQ_LEN_MAX; i++) begin
            m[i] = (i < k);
        end
        return m;
    endfunction

    // The first received bit sits at pattern[len-1], so the first k bits are
    // the top k bits of the pattern shifted down to the LSBs.
    function automatic logic [SEQ_LEN_MAX-1:0] pattern_prefix(
        input logic [SEQ_LEN_MAX-1:0] pattern,
        input int                     len,
        input int                     k
    );
        return (pattern >> (len - k)) & low_mask(k);
    endfunction

    // Longest proper border: largest k < len whose length-k suffix equals the
    // length-k prefix. Zero when the pattern has no self-overlap.
    function automatic int border_len(
        input logic [SEQ_LEN_MAX-1:0] pattern,
        input int                     len
    );
        int b;
        b = 0;
        for (int k = 1; k < len; k++) begin
            if ((pattern & low_mask(k)) == pattern_prefix(pattern, len, k)) begin
                b = k;
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that stops at all-ones instead of wrapping.
//   clk   : rising-edge clock
//   reset : asynchronous active-high clear
//   inc   : add one this cycle (ignored once saturated)
//   count : registered count value
// -----------------------------------------------------------------------------
module sat_counter
    import seq_det_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_r;

    // Count register: increments on inc, holds at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (inc && (count_r != {CNT_W{1'b1}})) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/mealy_seq_detector.sv
// -----------------------------------------------------------------------------
// mealy_seq_detector
// Parametrised Mealy serial sequence detector. One bit is consumed per clock
// while en=1; y rises combinationally in the cycle the final pattern bit is
// presented.
//   clk         : rising-edge clock
//   reset       : asynchronous active-high reset (state, history, counter)
//   en          : bit-valid qualifier
//   x           : serial data bit, PATTERN[LEN-1] arrives first
//   y           : match flag, en & (state==LEN-1) & (x==PATTERN[0])
//   state       : registered match depth
//   match_count : saturating match counter (only with MATCH_COUNT_EN defined)
// Build option: define MATCH_COUNT_EN to add the match_count port and counter.
// -----------------------------------------------------------------------------
module mealy_seq_detector
    import seq_det_pkg::*;
#(
    parameter int                     LEN     = 4,
    parameter logic [SEQ_LEN_MAX-1:0] PATTERN = 16'b1011,
    parameter bit                     OVERLAP = 1'b1,
    parameter int                     CNT_W   = 8,
    localparam int                    SW      = state_width(LEN)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             x,
    output logic             y,
    output logic [SW-1:0]    state
`ifdef MATCH_COUNT_EN
    ,
    output logic [CNT_W-1:0] match_count
`endif
);

    // Elaboration-time legality checks.
    if (LEN < 2 || LEN > SEQ_LEN_MAX) begin : g_bad_len
        $fatal(1, "mealy_seq_detector: LEN must be within 2..16");
    end
    if ((PATTERN >> LEN) != {SEQ_LEN_MAX{1'b0}}) begin : g_bad_pattern
        $fatal(1, "mealy_seq_detector: PATTERN wider than LEN");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $fatal(1, "mealy_seq_detector: CNT_W must be at least 1");
    end

    localparam logic [SW-1:0] S_EMPTY  = {SW{1'b0}};
    localparam logic [SW-1:0] S_LAST   = SW'(LEN - 1);
    localparam logic [SW-1:0] S_BORDER = SW'(border_len(PATTERN, LEN));

    logic [SW-1:0]          state_r;
    logic [SW-1:0]          state_nxt_s;
    logic [SW-1:0]          fallback_s;
    logic [LEN-2:0]         hist_r;
    logic [LEN-1:0]         window_s;
    logic [SEQ_LEN_MAX-1:0] window_ext_s;
    logic                   match_s;

    // Newest bit in the LSB: window holds the last LEN accepted bits if x is taken.
    assign window_s = {hist_r, x};
    assign match_s  = en & (state_r == S_LAST) & (x == PATTERN[0]);

    // Zero-extend the window so it can be masked against package helpers.
    always_comb begin
        window_ext_s             = {SEQ_LEN_MAX{1'b0}};
        window_ext_s[LEN-1:0]    = window_s;
    end

    // Fallback depth: longest k <= state+1 whose last k bits form the
    // pattern's first k bits. The k <= state+1 bound keeps bits already
    // consumed by a non-overlapping match from being reused.
    always_comb begin
        fallback_s = S_EMPTY;
        for (int k = 1; k < LEN; k++) begin
            if ((k <= int'(state_r) + 1) &&
                ((window_ext_s & low_mask(k)) == pattern_prefix(PATTERN, LEN, k))) begin
                fallback_s = SW'(k);
            end else begin
                fallback_s = fallback_s;
            end
        end
    end

    // Next-state selection: hold, restart after match, or fall back.
    always_comb begin
        if (!en) begin
            state_nxt_s = state_r;
        end else if (match_s) begin
            state_nxt_s = OVERLAP ? S_BORDER : S_EMPTY;
        end else begin
            state_nxt_s = fallback_s;
        end
    end

    // State and history registers; history shifts only on accepted bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_EMPTY;
            hist_r  <= {(LEN-1){1'b0}};
        end else if (en) begin
            state_r <= state_nxt_s;
            hist_r  <= window_s[LEN-2:0];
        end else begin
            state_r <= state_r;
            hist_r  <= hist_r;
        end
    end

    assign y     = match_s;
    assign state = state_r;

`ifdef MATCH_COUNT_EN
    sat_counter #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (match_s),
        .count (match_count)
    );
`endif

endmodule

// File: tb/tb_mealy_seq_detector.sv
// -----------------------------------------------------------------------------
// tb_mealy_seq_detector
// Four detector configurations share one stimulus stream. A driver pushes the
// expected response of each bit into a queue; a monitor pops and compares on
// the opposite clock edge. Expectations come from a model that simply keeps
// the accepted bits and searches them for the pattern.
// -----------------------------------------------------------------------------
module tb_mealy_seq_detector;

    localparam int NI = 4;

    logic clk;
    logic reset;
    logic en;
    logic x;

    logic       y0, y1, y2, y3;
    logic [1:0] s0, s1, s2;
    logic [2:0] s3;
`ifdef MATCH_COUNT_EN
    logic [7:0] c0, c2, c3;
    logic [1:0] c1;
`endif

    mealy_seq_detector #(.LEN(4), .PATTERN(16'b1011), .OVERLAP(1'b1), .CNT_W(8)) d0 (
        .clk(clk), .reset(reset), .en(en), .x(x), .y(y0), .state(s0)
`ifdef MATCH_COUNT_EN
        , .match_count(c0)
`endif
    );
    mealy_seq_detector #(.LEN(4), .PATTERN(16'b1010), .OVERLAP(1'b1), .CNT_W(2)) d1 (
        .clk(clk), .reset(reset), .en(en), .x(x), .y(y1), .state(s1)
`ifdef MATCH_COUNT_EN
        , .match_count(c1)
`endif
    );
    mealy_seq_detector #(.LEN(4), .PATTERN(16'b1010), .OVERLAP(1'b0), .CNT_W(8)) d2 (
        .clk(clk), .reset(reset), .en(en), .x(x), .y(y2), .state(s2)
`ifdef MATCH_COUNT_EN
        , .match_count(c2)
`endif
    );
    mealy_seq_detector #(.LEN(5), .PATTERN(16'b11011), .OVERLAP(1'b0), .CNT_W(8)) d3 (
        .clk(clk), .reset(reset), .en(en), .x(x), .y(y3), .state(s3)
`ifdef MATCH_COUNT_EN
        , .match_count(c3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int          plen [NI] = '{4, 4, 4, 5};
    logic [15:0] ppat [NI] = '{16'b1011, 16'b1010, 16'b1010, 16'b11011};
    bit          povl [NI] = '{1'b1, 1'b1, 1'b0, 1'b0};
    int          cmax [NI] = '{255, 3, 255, 255};
    int          mcnt [NI];
    bit          seen [NI][$];

    function automatic void model_reset();
        for (int i = 0; i < NI; i++) begin
            seen[i].delete();
            mcnt[i] = 0;
        end
    endfunction

    // Longest tail of the usable bits that is a proper prefix of the pattern.
    function automatic int model_state(int i);
        int n;
        n = seen[i].size();
        for (int k = plen[i] - 1; k >= 1; k--) begin
            if (n >= k) begin
                bit ok;
                ok = 1'b1;
                for (int j = 0; j < k; j++) begin
                    if (seen[i][n-k+j] != ppat[i][plen[i]-1-j]) ok = 1'b0;
                end
                if (ok) return k;
            end
        end
        return 0;
    endfunction

    // Accept one bit; report whether the last LEN usable bits are the pattern.
    function automatic bit model_step(int i, bit xb);
        bit hit;
        seen[i].push_back(xb);
        while (seen[i].size() > plen[i]) void'(seen[i].pop_front());
        hit = (seen[i].size() == plen[i]);
        for (int j = 0; j < plen[i]; j++) begin
            if (hit && seen[i][j] != ppat[i][plen[i]-1-j]) hit = 1'b0;
        end
        if (hit) begin
            if (mcnt[i] < cmax[i]) mcnt[i]++;
            if (!povl[i]) seen[i].delete();
        end
        return hit;
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [3:0]      y;
        logic [3:0][3:0] st;
        logic [3:0][7:0] cnt;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(string name, int i, int got, int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s[%0d] @%0t: got %0d expected %0d", name, i, $time, got, want);
        end
    endtask

    function automatic int dut_y(int i);
        case (i)
            0: return int'(y0);
            1: return int'(y1);
            2: return int'(y2);
            default: return int'(y3);
        endcase
    endfunction

    function automatic int dut_s(int i);
        case (i)
            0: return int'(s0);
            1: return int'(s1);
            2: return int'(s2);
            default: return int'(s3);
        endcase
    endfunction

`ifdef MATCH_COUNT_EN
    function automatic int dut_c(int i);
        case (i)
            0: return int'(c0);
            1: return int'(c1);
            2: return int'(c2);
            default: return int'(c3);
        endcase
    endfunction
`endif

    // Monitor: compare the pending expectation on the falling edge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            for (int m = 0; m < NI; m++) begin
                check("y", m, dut_y(m), int'(e.y[m]));
                check("state", m, dut_s(m), int'(e.st[m]));
`ifdef MATCH_COUNT_EN
                check("match_count", m, dut_c(m), int'(e.cnt[m]));
`endif
            end
        end
    end

    // ---------------- driver ----------------
    task automatic apply(bit e_b, bit x_b);
        exp_t r;
        @(posedge clk);
        #1;
        en = e_b;
        x  = x_b;
        for (int i = 0; i < NI; i++) begin
            r.st[i]  = 4'(model_state(i));
            r.cnt[i] = 8'(mcnt[i]);
            r.y[i]   = e_b ? model_step(i, x_b) : 1'b0;
        end
        q.push_back(r);
    endtask

    task automatic feed(input bit bits[], input int n);
        for (int i = 0; i < n; i++) apply(1'b1, bits[i]);
    endtask

    // Asynchronous reset between edges, with en=1 and x=1 presented.
    task automatic reset_now();
        reset = 1'b1;
        en    = 1'b1;
        x     = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) begin
            check("reset_y", i, dut_y(i), 0);
            check("reset_state", i, dut_s(i), 0);
`ifdef MATCH_COUNT_EN
            check("reset_count", i, dut_c(i), 0);
`endif
        end
        en = 1'b0;
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    bit s_a[]   = '{1, 0, 1, 1, 0, 1, 1};
    bit s_b[]   = '{1, 0, 1, 0, 1, 0};
    bit s_101[] = '{1, 0, 1};

    initial begin
        int waited;
        reset = 1'b1;
        en    = 1'b0;
        x     = 1'b0;
        model_reset();
        #3;
        for (int i = 0; i < NI; i++) begin
            check("por_y", i, dut_y(i), 0);
            check("por_state", i, dut_s(i), 0);
`ifdef MATCH_COUNT_EN
            check("por_count", i, dut_c(i), 0);
`endif
        end
        @(posedge clk);
        #2;
        reset = 1'b0;

        // Overlapping 1011 stream.
        feed(s_a, 7);
        @(posedge clk); #2; reset_now();

        // 1010 stream, overlap vs restart.
        feed(s_b, 6);
        @(posedge clk); #2; reset_now();

        // Mid-stream reset after 1,0,1.
        feed(s_101, 3);
        @(posedge clk); #2;
        check("pre_reset_state", 0, dut_s(0), 3);
        reset_now();

        // en gating: hold at depth 3 through idle cycles, then complete.
        feed(s_101, 3);
        for (int i = 0; i < 3; i++) apply(1'b0, 1'b1);
        apply(1'b1, 1'b1);
        @(posedge clk); #2; reset_now();

        // Six back-to-back 10 pairs: five matches on the overlapping 1010 unit.
        for (int i = 0; i < 6; i++) begin
            apply(1'b1, 1'b1);
            apply(1'b1, 1'b0);
        end
        apply(1'b0, 1'b0);
        @(posedge clk); #2; reset_now();

        // Randomised stream with idle cycles.
        for (int i = 0; i < 600; i++) begin
            apply(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
        end
        apply(1'b0, 1'b0);

        waited = 0;
        while (q.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        n_cmp++;
        if (q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
